imo_sequencer: RTL



---
 rtl/imo_sequencer_pkg.sv | 77 +++++++
 rtl/imo_sequencer_rng.sv | 70 +++++++
 rtl/imo_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imo_sequencer_pkg.sv
// Shared encodings for the IMO sequencer: instruction fields, opcodes,
// internal arbiter commands, response layout and FSM states.
package imo_sequencer_pkg;

    localparam int unsigned IMO_INST_W        = 128;
    localparam int unsigned IMO_OP_OFS        = 96;
    localparam int unsigned IMO_OP_SZ         = 6;
    localparam int unsigned IMO_RNGBUFSZ_OFS  = 0;
    localparam int unsigned IMO_RNG_OFS       = 1;
    localparam int unsigned IMO_WR_CR_OFS     = 2;
    localparam int unsigned IMO_RLRD_OFS      = 3;
    localparam int unsigned IMO_COPY_OFS      = 4;
    localparam int unsigned IMO_MCOPY_OFS     = 5;

    localparam int unsigned DST_ROW_OFS       = 0;
    localparam int unsigned SRC_ROW_OFS       = 32;
    localparam int unsigned CR_ADDR_OFS       = 32;
    localparam int unsigned COUNT_OFS         = 64;
    localparam int unsigned COUNT_W           = 16;
    localparam int unsigned CR_DATA_W         = 32;
    localparam int unsigned RNG_WORD_W        = 32;

    localparam int unsigned INT_CMD_SZ        = 2;
    localparam int unsigned INT_RLRD_OFS      = 0;
    localparam int unsigned INT_COPY_OFS      = 1;
    localparam logic [INT_CMD_SZ-1:0] CMD_RLRD = INT_CMD_SZ'(1) << INT_RLRD_OFS;
    localparam logic [INT_CMD_SZ-1:0] CMD_COPY = INT_CMD_SZ'(1) << INT_COPY_OFS;

    localparam int unsigned RESP_W            = 512;
    localparam int unsigned RESP_DONE_BIT     = 511;
    localparam int unsigned RESP_ERR_BIT      = 510;
    localparam int unsigned RESP_PAYLOAD_W    = 510;

    typedef struct packed {
        logic                      done;
        logic                      error;
        logic [RESP_PAYLOAD_W-1:0] payload;
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RNGW,
        ST_ISSUE,
        ST_RESP
    } seq_state_e;

    typedef enum logic [2:0] {
        OP_RNGBUFSZ,
        OP_RNG,
        OP_WR_CR,
        OP_RLRD,
        OP_COPY,
        OP_MCOPY,
        OP_ILLEGAL
    } op_e;

    // Priority decode of the one-hot opcode field.
    function automatic op_e decode_op(input logic [IMO_OP_SZ-1:0] op);
        if (op[IMO_RNGBUFSZ_OFS])   return OP_RNGBUFSZ;
        else if (op[IMO_RNG_OFS])   return OP_RNG;
        else if (op[IMO_WR_CR_OFS]) return OP_WR_CR;
        else if (op[IMO_RLRD_OFS])  return OP_RLRD;
        else if (op[IMO_COPY_OFS])  return OP_COPY;
        else if (op[IMO_MCOPY_OFS]) return OP_MCOPY;
        return OP_ILLEGAL;
    endfunction

    function automatic resp_t mk_resp(input logic done, input logic err,
                                      input logic [31:0] val);
        resp_t r;
        r.done    = done;
        r.error   = err;
        r.payload = RESP_PAYLOAD_W'(val);
        return r;
    endfunction

endpackage

// File: rtl/imo_sequencer_rng.sv
// imo_rng_buffer: packs RNG beats LSB-first into 32-bit words and queues
// them in a synchronous FIFO; completed words are dropped when full.
module imo_rng_buffer
    import imo_sequencer_pkg::*;
#(
    parameter int unsigned RNG_BITS_W = 4,
    parameter int unsigned RNG_DEPTH  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rng_valid,
    input  logic [RNG_BITS_W-1:0]        rng_bits,
    input  logic                         pop,
    output logic [RNG_WORD_W-1:0]        rd_data,
    output logic [$clog2(RNG_DEPTH):0]   count,
    output logic                         full
);

    localparam int unsigned BEATS = RNG_WORD_W / RNG_BITS_W;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned AW    = $clog2(RNG_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [RNG_WORD_W-1:0] word_q;
    logic [RNG_WORD_W-1:0] word_c;
    logic [IDX_W-1:0]      beat_idx;
    logic                  push_c;
    logic                  wr_en_c;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CNT_W-1:0]      count_d;
    logic [RNG_WORD_W-1:0] mem [RNG_DEPTH];

    // New beats enter at the top and shift down, so the first beat ends at the LSBs.
    assign word_c  = {rng_bits, word_q[RNG_WORD_W-1:RNG_BITS_W]};
    assign push_c  = rng_valid && (beat_idx == IDX_W'(BEATS - 1));
    assign wr_en_c = push_c && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (wr_en_c && !pop)      count_d = count + CNT_W'(1);
        else if (!wr_en_c && pop) count_d = count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            beat_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
        end else begin
            if (rng_valid) begin
                word_q   <= word_c;
                beat_idx <= push_c ? '0 : beat_idx + IDX_W'(1);
            end
            if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CNT_W'(RNG_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= word_c;
    end

endmodule

// File: rtl/imo_sequencer.sv
// IMO instruction sequencer: answers RNG/CR ops locally, issues RLRD/COPY/MCOPY
// to the DRAM arbiter. Optional ack timeout under IMO_SEQ_TIMEOUT_EN.
module imo_sequencer
    import imo_sequencer_pkg::*;
#(
    parameter int unsigned ROW_ADDR_W     = 30,
    parameter int unsigned RNG_BITS_W     = 4,
    parameter int unsigned RNG_DEPTH      = 64,
    parameter int unsigned CR_ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ack,
    input  logic [IMO_INST_W-1:0]   req_inst,
    output logic                    resp_valid,
    output logic [RESP_W-1:0]       resp_data,
    output logic                    arb_valid,
    output logic [INT_CMD_SZ-1:0]   arb_cmd,
    output logic [2*ROW_ADDR_W-1:0] arb_addr,
    input  logic                    arb_ack,
    input  logic                    rng_valid,
    input  logic [RNG_BITS_W-1:0]   rng_bits,
    output logic                    rng_fifo_full,
    output logic                    cr_wvalid,
    output logic [CR_ADDR_W-1:0]    cr_waddr,
    output logic [CR_DATA_W-1:0]    cr_wdata,
    output logic                    busy
);

    localparam int unsigned RNG_CNT_W = $clog2(RNG_DEPTH) + 1;

    seq_state_e state, state_d;
    resp_t      resp_q, resp_d;

    logic                    req_ack_d, resp_valid_d, arb_valid_d, cr_wvalid_d;
    logic [INT_CMD_SZ-1:0]   arb_cmd_d;
    logic [2*ROW_ADDR_W-1:0] arb_addr_d;
    logic [CR_ADDR_W-1:0]    cr_waddr_d;
    logic [CR_DATA_W-1:0]    cr_wdata_d;
    logic [COUNT_W-1:0]      rem_cnt, rem_cnt_d, issued, issued_d;

    logic [RNG_CNT_W-1:0]    rng_count;
    logic [RNG_WORD_W-1:0]   rng_word;
    logic                    rng_pop_c;
    logic                    rng_empty_c;
    logic                    accept_c;
    logic                    timeout_c;
    op_e                     op_c;
    logic [ROW_ADDR_W-1:0]   dst_row_c, src_row_c, nxt_src_c, nxt_dst_c;
    logic [COUNT_W-1:0]      count_c;
    logic                    unused_cfg;

    assign op_c        = decode_op(req_inst[IMO_OP_OFS +: IMO_OP_SZ]);
    assign dst_row_c   = req_inst[DST_ROW_OFS +: ROW_ADDR_W];
    assign src_row_c   = req_inst[SRC_ROW_OFS +: ROW_ADDR_W];
    assign count_c     = req_inst[COUNT_OFS +: COUNT_W];
    assign nxt_src_c   = arb_addr[ROW_ADDR_W +: ROW_ADDR_W] + ROW_ADDR_W'(1);
    assign nxt_dst_c   = arb_addr[0 +: ROW_ADDR_W] + ROW_ADDR_W'(1);
    assign rng_empty_c = (rng_count == '0);
    // Blocking on req_ack keeps a held req_valid from being accepted twice.
    assign accept_c    = (state == ST_IDLE) && req_valid && !req_ack;
    assign busy        = (state != ST_IDLE);
    assign resp_data   = resp_q;
    assign unused_cfg  = ^{req_inst, (TIMEOUT_CYCLES != 0)};

    imo_rng_buffer #(
        .RNG_BITS_W (RNG_BITS_W),
        .RNG_DEPTH  (RNG_DEPTH)
    ) u_rng (
        .clk       (clk),
        .rst_n     (rst_n),
        .rng_valid (rng_valid),
        .rng_bits  (rng_bits),
        .pop       (rng_pop_c),
        .rd_data   (rng_word),
        .count     (rng_count),
        .full      (rng_fifo_full)
    );

`ifdef IMO_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign timeout_c = (state == ST_ISSUE) && arb_valid && !arb_ack &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive un-acked cycles of the current command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     tmo_cnt <= '0;
        else if (state != ST_ISSUE || arb_ack)          tmo_cnt <= '0;
        else if (arb_valid)                             tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ack    <= 1'b0;
            resp_valid <= 1'b0;
            resp_q     <= '0;
            arb_valid  <= 1'b0;
            arb_cmd    <= '0;
            arb_addr   <= '0;
            cr_wvalid  <= 1'b0;
            cr_waddr   <= '0;
            cr_wdata   <= '0;
            rem_cnt    <= '0;
            issued     <= '0;
        end else begin
            state      <= state_d;
            req_ack    <= req_ack_d;
            resp_valid <= resp_valid_d;
            resp_q     <= resp_d;
            arb_valid  <= arb_valid_d;
            arb_cmd    <= arb_cmd_d;
            arb_addr   <= arb_addr_d;
            cr_wvalid  <= cr_wvalid_d;
            cr_waddr   <= cr_waddr_d;
            cr_wdata   <= cr_wdata_d;
            rem_cnt    <= rem_cnt_d;
            issued     <= issued_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    unique case (op_c)
                        OP_RNG:          if (rng_empty_c) state_d = ST_RNGW;
                        OP_RLRD, OP_COPY: state_d = ST_ISSUE;
                        OP_MCOPY:        state_d = (count_c == '0) ? ST_RESP : ST_ISSUE;
                        default:         state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RNGW:  if (!rng_empty_c) state_d = ST_IDLE;
            ST_ISSUE: if ((arb_ack && rem_cnt == COUNT_W'(1)) || timeout_c) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; responses are prepared on entry to RESP.
    always_comb begin
        req_ack_d    = 1'b0;
        resp_valid_d = 1'b0;
        resp_d       = resp_q;
        arb_valid_d  = arb_valid;
        arb_cmd_d    = arb_cmd;
        arb_addr_d   = arb_addr;
        cr_wvalid_d  = 1'b0;
        cr_waddr_d   = cr_waddr;
        cr_wdata_d   = cr_wdata;
        rem_cnt_d    = rem_cnt;
        issued_d     = issued;
        rng_pop_c    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    req_ack_d = 1'b1;
                    issued_d  = '0;
                    unique case (op_c)
                        OP_RNGBUFSZ: begin
                            resp_valid_d = 1'b1;
                            resp_d       = mk_resp(1'b0, 1'b0, 32'(rng_count));
                        end
                        OP_RNG: begin
                            if (!rng_empty_c) begin
                                rng_pop_c    = 1'b1;
                                resp_valid_d = 1'b1;
                                resp_d       = mk_resp(1'b0, 1'b0, rng_word);
                            end
                        end
                        OP_WR_CR: begin
                            cr_wvalid_d  = 1'b1;
                            cr_waddr_d   = req_inst[CR_ADDR_OFS +: CR_ADDR_W];
                            cr_wdata_d   = req_inst[0 +: CR_DATA_W];
                            resp_valid_d = 1'b1;
                            resp_d       = mk_resp(1'b0, 1'b0, 32'd0);
                        end
                        OP_RLRD: begin
                            arb_valid_d = 1'b1;
                            arb_cmd_d   = CMD_RLRD;
                            arb_addr_d  = {ROW_ADDR_W'(0), dst_row_c};
                            rem_cnt_d   = COUNT_W'(1);
                        end
                        OP_COPY: begin
                            arb_valid_d = 1'b1;
                            arb_cmd_d   = CMD_COPY;
                            arb_addr_d  = {src_row_c, dst_row_c};
                            rem_cnt_d   = COUNT_W'(1);
                        end
                        OP_MCOPY: begin
                            if (count_c == '0) begin
                                resp_valid_d = 1'b1;
                                resp_d       = mk_resp(1'b1, 1'b0, 32'd0);
                            end else begin
                                arb_valid_d = 1'b1;
                                arb_cmd_d   = CMD_COPY;
                                arb_addr_d  = {src_row_c, dst_row_c};
                                rem_cnt_d   = count_c;
                            end
                        end
                        default: begin
                            resp_valid_d = 1'b1;
                            resp_d       = mk_resp(1'b1, 1'b1, 32'd0);
                        end
                    endcase
                end
            end
            ST_RNGW: begin
                if (!rng_empty_c) begin
                    rng_pop_c    = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_d       = mk_resp(1'b0, 1'b0, rng_word);
                end
            end
            ST_ISSUE: begin
                if (arb_ack) begin
                    issued_d = issued + COUNT_W'(1);
                    if (rem_cnt == COUNT_W'(1)) begin
                        arb_valid_d  = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_d       = mk_resp(1'b1, 1'b0, 32'(issued_d));
                    end else begin
                        rem_cnt_d  = rem_cnt - COUNT_W'(1);
                        arb_addr_d = {nxt_src_c, nxt_dst_c};
                    end
                end else if (timeout_c) begin
                    arb_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_d       = mk_resp(1'b1, 1'b1, 32'(issued));
                end
            end
            default: ;
        endcase
    end

endmodule
